// File: rtl/bus_arbiter.sv
// bus_arbiter: two-core snooping bus arbiter with L2 access; BUS_TIMEOUT_EN enables a HOLD_MAX grant timeout
module bus_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_core,
  output logic [1:0]       grant,
  input  logic [1:0][1:0]  core_operation,
  input  logic [1:0][31:0] core_address,
  input  logic [1:0][31:0] core_data,
  input  logic [1:0]       core_flush,
  input  logic [1:0]       core_hit,
  output logic [1:0][1:0]  snoop_operation,
  output logic [31:0]      snoop_address,
  output logic [31:0]      resp_data,
  output logic [1:0]       resp_hit,
  output logic             l2_rd_en,
  output logic             l2_wr_en,
  output logic [31:0]      l2_addr,
  output logic [31:0]      l2_wdata,
  input  logic [31:0]      l2_rdata,
  input  logic             l2_ready
);
  typedef enum logic [2:0] {IDLE, GRANT, EVICT, SNOOP, WB, L2RD, RESP} state_t;
  localparam logic [1:0] BUS_UPGR = 2'b01;
  localparam logic [1:0] BUS_NON  = 2'b11;
  state_t      state, nxt;
  logic        owner, last_owner, hit_q, drop, timeout;
  logic        other;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  assign other = ~owner;
  assign drop = !req_core[owner];
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt;
  // cycles spent granted, cleared whenever the bus is idle
  always_ff @(posedge clk)
    if (reset || state == IDLE) cnt <= '0;
    else cnt <= cnt + 1'b1;
  assign timeout = (state != IDLE) && (cnt == CW'(HOLD_MAX - 1));
`else
  assign timeout = 1'b0;
`endif
  // next-state logic; a dropped request aborts, a timeout forces release
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = |req_core ? GRANT : IDLE;
      GRANT: nxt = drop ? IDLE : core_flush[owner] ? EVICT : (core_operation[owner] != BUS_NON) ? SNOOP : GRANT;
      EVICT: nxt = drop ? IDLE : l2_ready ? GRANT : EVICT;
      SNOOP: nxt = drop ? IDLE : (op_q == BUS_UPGR) ? RESP : core_flush[other] ? WB : L2RD;
      WB:    nxt = drop ? IDLE : l2_ready ? RESP : WB;
      L2RD:  nxt = drop ? IDLE : l2_ready ? RESP : L2RD;
      RESP:  nxt = drop ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
    if (timeout) nxt = IDLE;
  end
  // state register plus transaction datapath captured on transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      hit_q      <= 1'b0;
      op_q       <= BUS_NON;
      addr_q     <= '0;
      resp_data  <= '0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |req_core) owner <= (&req_core) ? ~last_owner : req_core[1];
      if (state == GRANT && nxt == EVICT) begin
        l2_addr  <= core_address[owner];
        l2_wdata <= core_data[owner];
      end
      if (state == GRANT && nxt == SNOOP) begin
        op_q   <= core_operation[owner];
        addr_q <= core_address[owner];
      end
      if (state == SNOOP) begin
        hit_q   <= core_hit[other];
        l2_addr <= addr_q;
      end
      if (state == SNOOP && nxt == WB) begin
        resp_data <= core_data[other];
        l2_wdata  <= core_data[other];
      end
      if (state == L2RD && nxt == RESP) resp_data <= l2_rdata;
      if ((state == RESP && drop) || timeout) last_owner <= owner;
    end
  end
  // outputs decoded from state; owner always sees BusNoN
  always_comb begin
    snoop_operation = {BUS_NON, BUS_NON};
    if (state == SNOOP) snoop_operation[other] = op_q;
    grant    = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
    resp_hit = (state == RESP) ? (owner ? {hit_q, 1'b0} : {1'b0, hit_q}) : 2'b00;
    l2_rd_en = (state == L2RD);
    l2_wr_en = (state == WB) || (state == EVICT);
  end
  assign snoop_address = addr_q;
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: max cycles one grant may be held (used only with BUS_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_core  input  2  bus request, bit i from core i.
REQ-005 SHALL have port grant  output  2  one-hot bus grant, bit i to core i.
REQ-006 SHALL have port core_operation  input  2x2  per-core bus op: BusRd=00, BusUpgr=01, BusRdX=10, BusNoN=11.
REQ-007 SHALL have port core_address  input  2x32  per-core bus address.
REQ-008 SHALL have port core_data  input  2x32  per-core bus data (flush/writeback data).
REQ-009 SHALL have port core_flush  input  2  core i supplies dirty line on core_data[i].
REQ-010 SHALL have port core_hit  input  2  snoop hit reported by core i.
REQ-011 SHALL have port snoop_operation  output  2x2  op broadcast to core i; BusNoN when idle.
REQ-012 SHALL have port snoop_address  output  32  broadcast address.
REQ-013 SHALL have port resp_data  output  32  fill data to granted core.
REQ-014 SHALL have port resp_hit  output  2  to core i: other core held the line (shared).
REQ-015 SHALL have ports l2_rd_en, l2_wr_en  output  1 each; l2_addr, l2_wdata  output  32; l2_rdata  input  32; l2_ready  input  1: L2 word access.

Function
REQ-016 SHALL implement FSM IDLE -> GRANT -> SNOOP -> (WB | L2RD | RESP) -> RESP -> IDLE.
REQ-017 IDLE: with any req_core set, SHALL pick round-robin (core != last_owner wins on tie) and assert grant next cycle.
REQ-018 GRANT: SHALL wait while owner core_operation = 11; on op != 11 SHALL latch op, address, data and enter SNOOP.
REQ-019 SNOOP: SHALL drive latched op/address to non-owner core for exactly 1 cycle, then sample core_hit/core_flush of non-owner.
REQ-020 BusUpgr: SHALL skip L2, go to RESP.
REQ-021 BusRd/BusRdX with non-owner flush: SHALL forward non-owner core_data to resp_data and enter WB, writing it to L2 (l2_wr_en held until l2_ready).
REQ-022 BusRd/BusRdX with no flush: SHALL enter L2RD, hold l2_rd_en until l2_ready, capture l2_rdata into resp_data.
REQ-023 Owner core_flush during GRANT (eviction): SHALL write core_data[owner] to L2 before servicing op.
REQ-024 RESP: SHALL hold resp_data, resp_hit[owner] = sampled hit, until owner drops req_core; then drop grant, update last_owner, return IDLE.
REQ-025 Owner dropping req_core in any state before RESP SHALL abort: grant, l2_rd_en, l2_wr_en low next cycle, IDLE.
REQ-026 grant SHALL never have more than one bit set; snoop_operation of owner SHALL stay 11.
REQ-027 l2_rd_en and l2_wr_en SHALL never be high together.

Reset
REQ-028 On reset: state IDLE, grant=00, snoop_operation=11 for both, snoop_address=0, resp_data=0, resp_hit=00, l2_rd_en=l2_wr_en=0, l2_addr=l2_wdata=0, last_owner=1 (core 0 wins first tie).
REQ-029 Reset mid-transaction SHALL abandon it with no further L2 access.

Configuration
REQ-030 Macro BUS_TIMEOUT_EN defined: counter SHALL force grant release to IDLE after HOLD_MAX cycles granted, last_owner updated; L2 strobes dropped same cycle.
REQ-031 BUS_TIMEOUT_EN undefined: no counter; grant held until owner drops req_core.

Verification
REQ-032 req_core=11 after reset -> grant=01 next cycle; after completion and re-request, grant=10.
REQ-033 Core0 BusRd 0x100, core1 hit+flush data 0xDEADBEEF -> resp_data=0xDEADBEEF, resp_hit[0]=1, one L2 write of 0xDEADBEEF to 0x100.
REQ-034 Core1 BusRdX 0x40, no snoop hit, L2 ready after 3 cycles with 0x12345678 -> resp_data=0x12345678, resp_hit[1]=0, snoop_operation[0]=10 for 1 cycle.
REQ-035 Core0 BusUpgr 0x80 -> no l2_rd_en/l2_wr_en, snoop_operation[1]=01 one cycle, RESP reached.
REQ-036 Reset asserted during L2RD -> next cycle grant=00, l2_rd_en=0, state IDLE.
REQ-037 BUS_TIMEOUT_EN, HOLD_MAX=16, core0 holds op=11 -> grant[0] drops after 16 cycles; pending core1 granted next.
